// File: rtl/axi_id_slot_alloc_if.sv
// Request/response bundle for the AXI ID slot allocator.
// Optional statistics outputs are present when AXI_ID_ALLOC_STATS_EN is defined.
interface axi_id_slot_alloc_if #(
  parameter int ID_IN_WIDTH = 6,
  parameter int ID_SLOT     = 16
);
  localparam int SLOT_W = (ID_SLOT > 1) ? $clog2(ID_SLOT) : 1;

  logic                   alloc_valid_i;
  logic [ID_IN_WIDTH-1:0] alloc_id_i;
  logic                   alloc_ready_o;
  logic [SLOT_W-1:0]      alloc_slot_o;
  logic                   free_valid_i;
  logic [SLOT_W-1:0]      free_slot_i;
  logic [ID_IN_WIDTH-1:0] free_id_o;
  logic                   free_err_o;
  logic [SLOT_W:0]        busy_cnt_o;
  logic                   full_o;
  logic                   drain_req_i;
  logic                   drain_done_o;

`ifdef AXI_ID_ALLOC_STATS_EN
  logic [31:0]            stall_cnt_o;
  logic [31:0]            hit_cnt_o;

  modport master (
    output alloc_valid_i, alloc_id_i, free_valid_i, free_slot_i, drain_req_i,
    input  alloc_ready_o, alloc_slot_o, free_id_o, free_err_o, busy_cnt_o,
           full_o, drain_done_o, stall_cnt_o, hit_cnt_o
  );

  modport slave (
    input  alloc_valid_i, alloc_id_i, free_valid_i, free_slot_i, drain_req_i,
    output alloc_ready_o, alloc_slot_o, free_id_o, free_err_o, busy_cnt_o,
           full_o, drain_done_o, stall_cnt_o, hit_cnt_o
  );
`else
  modport master (
    output alloc_valid_i, alloc_id_i, free_valid_i, free_slot_i, drain_req_i,
    input  alloc_ready_o, alloc_slot_o, free_id_o, free_err_o, busy_cnt_o,
           full_o, drain_done_o
  );

  modport slave (
    input  alloc_valid_i, alloc_id_i, free_valid_i, free_slot_i, drain_req_i,
    output alloc_ready_o, alloc_slot_o, free_id_o, free_err_o, busy_cnt_o,
           full_o, drain_done_o
  );
`endif
endinterface

// File: rtl/axi_id_slot_alloc.sv
// AXI ID remap slot allocator: maps wide incoming IDs onto ID_SLOT outgoing
// slots, counts outstanding transactions per slot, releases slots on final
// responses and returns the original ID for the response path.
// A drain FSM (RUN/DRAIN/DONE) can block new allocations until the table empties.
// Optional statistics counters: define AXI_ID_ALLOC_STATS_EN.
module axi_id_slot_alloc #(
  parameter int ID_IN_WIDTH = 6,
  parameter int ID_SLOT     = 16,
  parameter int CNT_WIDTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  axi_id_slot_alloc_if.slave bus
);

  localparam int SLOT_W = (ID_SLOT > 1) ? $clog2(ID_SLOT) : 1;
  localparam int BUSY_W = SLOT_W + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Per-slot table: original ID and outstanding transaction count.
  logic [ID_IN_WIDTH-1:0] id_q  [ID_SLOT];
  logic [CNT_WIDTH-1:0]   cnt_q [ID_SLOT];

  logic [ID_SLOT-1:0]     in_use;
  logic                   hit;
  logic [SLOT_W-1:0]      hit_slot;
  logic [CNT_WIDTH-1:0]   hit_cnt_val;
  logic                   free_found;
  logic [SLOT_W-1:0]      empty_slot;
  logic [BUSY_W-1:0]      busy_cnt;

  logic                   alloc_ready;
  logic [SLOT_W-1:0]      alloc_slot;
  logic                   accept;

  logic [ID_IN_WIDTH-1:0] free_id;
  logic                   free_cnt_nz;
  logic                   free_ok;
  logic                   free_err_d;
  logic                   free_err_q;

  logic [ID_SLOT-1:0]     acc_vec;
  logic [ID_SLOT-1:0]     fr_vec;

  // Saturating 32-bit increment for the statistics counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counter step helpers; callers guarantee no wrap (ready gates increment,
  // free_ok gates decrement).
  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    return v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_dec(input logic [CNT_WIDTH-1:0] v);
    return v - CNT_WIDTH'(1);
  endfunction

  // Lookup on registered state: ID hit, lowest free slot and busy population.
  // The loop runs from the top down so the lowest matching index wins.
  always_comb begin
    in_use      = '0;
    hit         = 1'b0;
    hit_slot    = '0;
    hit_cnt_val = '0;
    free_found  = 1'b0;
    empty_slot  = '0;
    busy_cnt    = '0;
    for (int i = ID_SLOT - 1; i >= 0; i--) begin
      in_use[i] = (cnt_q[i] != '0);
      if (in_use[i] && (id_q[i] == bus.alloc_id_i)) begin
        hit         = 1'b1;
        hit_slot    = SLOT_W'(i);
        hit_cnt_val = cnt_q[i];
      end
      if (!in_use[i]) begin
        free_found = 1'b1;
        empty_slot = SLOT_W'(i);
      end
      busy_cnt = busy_cnt + BUSY_W'(in_use[i]);
    end
  end

  // Slot choice and ready. An in-flight ID never moves to another slot, so a
  // saturated hit stalls rather than spilling over; non-RUN states block all.
  always_comb begin
    alloc_slot  = '0;
    alloc_ready = 1'b0;
    if (hit) begin
      alloc_slot  = hit_slot;
      alloc_ready = (hit_cnt_val != CNT_MAX);
    end else if (free_found) begin
      alloc_slot  = empty_slot;
      alloc_ready = 1'b1;
    end
    if (state_q != ST_RUN) begin
      alloc_ready = 1'b0;
    end
  end

  assign accept = bus.alloc_valid_i & alloc_ready;

  // Free-side lookup; an index outside the table matches nothing and so
  // behaves like a free to an empty slot.
  always_comb begin
    free_id     = '0;
    free_cnt_nz = 1'b0;
    for (int i = 0; i < ID_SLOT; i++) begin
      if (bus.free_slot_i == SLOT_W'(i)) begin
        free_id     = id_q[i];
        free_cnt_nz = (cnt_q[i] != '0);
      end
    end
  end

  assign free_ok    = bus.free_valid_i & free_cnt_nz;
  assign free_err_d = bus.free_valid_i & ~free_cnt_nz;

  // Per-slot accept/free strobes feeding the table update.
  always_comb begin
    acc_vec = '0;
    fr_vec  = '0;
    for (int i = 0; i < ID_SLOT; i++) begin
      acc_vec[i] = accept  && (alloc_slot       == SLOT_W'(i));
      fr_vec[i]  = free_ok && (bus.free_slot_i  == SLOT_W'(i));
    end
  end

  // Table update. Accept and free on the same slot cancel out; a miss
  // claims the slot with count 1, a hit bumps the count, a free decrements it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ID_SLOT; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ID_SLOT; i++) begin
        if (acc_vec[i] && !fr_vec[i]) begin
          if (hit) begin
            cnt_q[i] <= cnt_inc(cnt_q[i]);
          end else begin
            id_q[i]  <= bus.alloc_id_i;
            cnt_q[i] <= CNT_WIDTH'(1);
          end
        end else if (fr_vec[i] && !acc_vec[i]) begin
          cnt_q[i] <= cnt_dec(cnt_q[i]);
        end
      end
    end
  end

  // Registered single-cycle error pulse for frees to empty/invalid slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_err_q <= 1'b0;
    end else begin
      free_err_q <= free_err_d;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM next state: RUN -> DRAIN on request, DRAIN -> DONE once empty,
  // back to RUN whenever the request drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.drain_req_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus.drain_req_i) begin
          state_d = ST_RUN;
        end else if (busy_cnt == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.drain_req_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.alloc_slot_o  = alloc_slot;
  assign bus.free_id_o     = free_id;
  assign bus.free_err_o    = free_err_q;
  assign bus.busy_cnt_o    = busy_cnt;
  assign bus.full_o        = &in_use;
  assign bus.drain_done_o  = (state_q == ST_DONE);

`ifdef AXI_ID_ALLOC_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] hit_cnt_q;

  // Statistics: stalled request cycles and accepted hits, both saturating.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      hit_cnt_q   <= '0;
    end else begin
      if (bus.alloc_valid_i && !alloc_ready) begin
        stall_cnt_q <= sat_inc32(stall_cnt_q);
      end
      if (accept && hit) begin
        hit_cnt_q <= sat_inc32(hit_cnt_q);
      end
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.hit_cnt_o   = hit_cnt_q;
`endif

endmodule

// File: tb/tb_axi_id_slot_alloc.sv
// Self-checking bench for axi_id_slot_alloc: directed steps followed by
// randomized traffic, compared against a table-level reference model.
module tb_axi_id_slot_alloc;

  localparam int ID_IN_WIDTH = 6;
  localparam int ID_SLOT     = 16;
  localparam int CNT_WIDTH   = 4;
  localparam int CMAX        = (1 << CNT_WIDTH) - 1;

  logic clk;
  logic rst;

  axi_id_slot_alloc_if #(.ID_IN_WIDTH(ID_IN_WIDTH), .ID_SLOT(ID_SLOT)) bus ();

  axi_id_slot_alloc #(
    .ID_IN_WIDTH(ID_IN_WIDTH),
    .ID_SLOT    (ID_SLOT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what each slot holds, drain phase (0 run, 1 draining,
  // 2 drained) and the error pulse expected after the last edge.
  int m_id  [ID_SLOT];
  int m_cnt [ID_SLOT];
  int m_st;
  bit m_err;
  int m_stall;
  int m_hits;
  bit dr_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_busy();
    int b = 0;
    for (int i = 0; i < ID_SLOT; i++) if (m_cnt[i] > 0) b++;
    return b;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ID_SLOT; i++) begin
      m_id[i]  = 0;
      m_cnt[i] = 0;
    end
    m_st = 0; m_err = 0; m_stall = 0; m_hits = 0;
  endtask

  // An ID already in flight must reuse its slot; otherwise the first empty slot.
  task automatic predict(input bit av, input int aid, output bit rdy, output int slot, output bit is_hit);
    bit found = 0;
    rdy = 0; slot = 0; is_hit = 0;
    for (int i = 0; i < ID_SLOT; i++)
      if (!is_hit && m_cnt[i] > 0 && m_id[i] == aid) begin is_hit = 1; slot = i; end
    if (is_hit) rdy = (m_cnt[slot] < CMAX);
    else begin
      for (int i = 0; i < ID_SLOT; i++)
        if (!found && m_cnt[i] == 0) begin found = 1; slot = i; end
      rdy = found;
    end
    if (m_st != 0) rdy = 0;
  endtask

  task automatic commit(input bit av, input int aid, input bit fv, input int fs, input bit dr,
                        input bit rdy, input int slot, input bit is_hit);
    bit acc = av && rdy;
    bit fok = fv && (fs < ID_SLOT) && (m_cnt[fs] > 0);
    int busy_pre = m_busy();
    if (av && !rdy) m_stall++;
    if (acc && is_hit) m_hits++;
    if (!(acc && fok && fs == slot)) begin
      if (acc) begin
        if (is_hit) m_cnt[slot]++;
        else begin m_id[slot] = aid; m_cnt[slot] = 1; end
      end
      if (fok) m_cnt[fs]--;
    end
    m_err = fv && !fok;
    case (m_st)
      0: if (dr) m_st = 1;
      1: if (!dr) m_st = 0; else if (busy_pre == 0) m_st = 2;
      default: if (!dr) m_st = 0;
    endcase
  endtask

  // One clock: drive, check combinational outputs, clock, check registered.
  task automatic cycle(input bit av, input int aid, input bit fv, input int fs, input bit dr);
    bit rdy, is_hit;
    int slot;
    bus.alloc_valid_i = av;
    bus.alloc_id_i    = aid[ID_IN_WIDTH-1:0];
    bus.free_valid_i  = fv;
    bus.free_slot_i   = fs[3:0];
    bus.drain_req_i   = dr;
    #2;
    predict(av, aid, rdy, slot, is_hit);
    chk("alloc_ready", 32'(bus.alloc_ready_o), 32'(rdy));
    chk("alloc_slot",  32'(bus.alloc_slot_o),  32'(slot));
    chk("busy_cnt",    32'(bus.busy_cnt_o),    32'(m_busy()));
    chk("full",        32'(bus.full_o),        32'(m_busy() == ID_SLOT));
    chk("drain_done",  32'(bus.drain_done_o),  32'(m_st == 2));
    if (fs < ID_SLOT && m_cnt[fs] > 0) chk("free_id", 32'(bus.free_id_o), 32'(m_id[fs]));
    @(posedge clk);
    commit(av, aid, fv, fs, dr, rdy, slot, is_hit);
    #1;
    chk("free_err", 32'(bus.free_err_o), 32'(m_err));
`ifdef AXI_ID_ALLOC_STATS_EN
    chk("stall_cnt", bus.stall_cnt_o, 32'(m_stall));
    chk("hit_cnt",   bus.hit_cnt_o,   32'(m_hits));
`endif
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i = 1'b0;
    bus.alloc_id_i    = '0;
    bus.free_valid_i  = 1'b0;
    bus.free_slot_i   = '0;
    bus.drain_req_i   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.alloc_ready_o), 32'd1);
    chk({tag, "_slot"},  32'(bus.alloc_slot_o),  32'd0);
    chk({tag, "_fid"},   32'(bus.free_id_o),     32'd0);
    chk({tag, "_busy"},  32'(bus.busy_cnt_o),    32'd0);
    chk({tag, "_full"},  32'(bus.full_o),        32'd0);
    chk({tag, "_done"},  32'(bus.drain_done_o),  32'd0);
    chk({tag, "_err"},   32'(bus.free_err_o),    32'd0);
  endtask

  initial begin
    int fs;
    int q[$];
    rst = 1'b1;
    idle_inputs();
    m_reset();
    #13;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // First allocation lands in slot 0; the ID is visible on the free side.
    cycle(1, 'h05, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("tp1_busy", 32'(bus.busy_cnt_o), 32'd1);
    chk("tp1_fid",  32'(bus.free_id_o),  32'h05);

    // Same ID until the counter saturates, stall, free one, then accept.
    for (int i = 0; i < 14; i++) cycle(1, 'h05, 0, 0, 0);
    cycle(1, 'h05, 0, 0, 0);
    cycle(1, 'h05, 1, 0, 0);
    cycle(1, 'h05, 0, 0, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // Fill every slot, stall a new ID, free slot 7 and reuse it.
    for (int i = 0; i < 16; i++) cycle(1, i, 0, 0, 0);
    #1;
    chk("tp3_full", 32'(bus.full_o), 32'd1);
    cycle(1, 'h20, 0, 0, 0);
    cycle(1, 'h20, 1, 7, 0);
    cycle(1, 'h20, 0, 7, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, i, 0);

    // Hit and free on the same slot in one cycle leave the entry alone.
    for (int i = 0; i < 4; i++) cycle(1, 'h10 + i, 0, 0, 0);
    cycle(1, 'h13, 0, 0, 0);
    cycle(1, 'h13, 1, 3, 0);
    cycle(0, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3, 0);

    // Free to an empty slot: one-cycle error pulse, table untouched.
    cycle(0, 0, 1, 9, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, i, 0);

    // Drain with three slots busy, then release and resume.
    for (int i = 0; i < 3; i++) cycle(1, 'h21 + i, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 'h24, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 'h24, 1, i, 1);
    for (int i = 0; i < 3; i++) cycle(1, 'h24, 0, 0, 1);
    cycle(1, 'h24, 0, 0, 0);
    cycle(1, 'h24, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // Randomized traffic with a small ID pool to force hits and saturation.
    dr_r = 0;
    for (int n = 0; n < 3000; n++) begin
      int aid;
      bit av, fv;
      aid = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4));
      av  = ($urandom_range(0, 3) != 0);
      fv  = ($urandom_range(0, 2) == 0);
      q.delete();
      for (int i = 0; i < ID_SLOT; i++) if (m_cnt[i] > 0) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 4) != 0) fs = q[$urandom_range(0, q.size() - 1)];
      else fs = $urandom_range(0, ID_SLOT - 1);
      if ($urandom_range(0, 79) == 0) dr_r = !dr_r;
      cycle(av, aid, fv, fs, dr_r);
    end

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check_reset_outputs("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, 'h3F, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_id_slot_alloc.md
Name: axi_id_slot_alloc

Overview:
Slot allocator and controller for the AXI ID remapper's ID table. It maps each incoming (wide) transaction ID to one of ID_SLOT outgoing slots and tracks how many transactions are outstanding per slot. Slots are released on B/R-last responses. The block also returns the original ID for the response path. One instance serves the AW channel and one serves the AR channel.

Parameters:
ID_IN_WIDTH, 6, width of incoming AXI ID
ID_SLOT, 16, number of remap slots; output ID width is $clog2(ID_SLOT)
CNT_WIDTH, 4, width of per-slot outstanding counter; max outstanding per slot = 2^CNT_WIDTH-1

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
alloc_valid_i  in  1  new AW/AR request present
alloc_id_i  in  ID_IN_WIDTH  incoming ID
alloc_ready_o  out  1  allocation can be accepted this cycle
alloc_slot_o  out  $clog2(ID_SLOT)  slot (outgoing ID) for alloc_id_i
free_valid_i  in  1  final response (B, or R with last) handshake on slot
free_slot_i  in  $clog2(ID_SLOT)  slot being released
free_id_o  out  ID_IN_WIDTH  original ID stored in free_slot_i
free_err_o  out  1  registered pulse: free issued to a slot with count 0
busy_cnt_o  out  $clog2(ID_SLOT)+1  number of slots in use
full_o  out  1  all slots in use
drain_req_i  in  1  request to block new allocations until empty
drain_done_o  out  1  drain complete, all slots free

Behaviour:
- Table state per slot: id[ID_IN_WIDTH], cnt[CNT_WIDTH]. A slot is in use when cnt != 0.
- Reset (async, rst_i=1): all cnt=0, all id=0, FSM=RUN, free_err_o=0, stats cleared. Combinational outputs then evaluate to: alloc_ready_o=alloc_valid-independent 1 (table empty, RUN), alloc_slot_o=0, free_id_o=0, busy_cnt_o=0, full_o=0, drain_done_o=0.
- Lookup is combinational on registered state only; a same-cycle free is not bypassed.
- Hit: the slot is in use and its id equals alloc_id_i. alloc_slot_o = hit slot. ready=1 iff cnt<max. A saturated hit stalls; a different slot is never allocated for an ID already in flight (this preserves AXI same-ID ordering).
- Miss: alloc_slot_o = lowest-index free slot. ready=1 iff a free slot exists. If none exists: ready=0, alloc_slot_o=0.
- ready is additionally forced to 0 in any FSM state other than RUN.
- Accept = alloc_valid_i & alloc_ready_o. On the next edge: on a miss, id[slot]<=alloc_id_i and cnt<=1; on a hit, cnt+1.
- Free: if cnt[free_slot_i]!=0, then cnt-1. If cnt==0, the table is unchanged and free_err_o=1 for one cycle.
- Accept and free on the same slot in the same cycle: cnt unchanged and id retained. The combined case of a miss allocation plus a free on a cnt=0 slot is an error free, so the allocation proceeds normally.
- free_id_o = id[free_slot_i], combinational. It is valid while the slot's cnt>0.
- busy_cnt_o and full_o are combinational from cnt!=0 flags.
- FSM:
  - RUN: if drain_req_i, go to DRAIN.
  - DRAIN: ready=0. When busy_cnt_o==0, go to DONE.
  - DONE: drain_done_o=1, ready=0. When drain_req_i==0, go to RUN.
  - If drain_req_i drops while in DRAIN, go to RUN.
  - A drain request with an already-empty table reaches DONE 2 cycles after drain_req_i rises.
- Out-of-range free_slot_i (>=ID_SLOT, non-power-of-2 case) is treated as an error free.

Optional Feature:
AXI_ID_ALLOC_STATS_EN:
- Adds the output stall_cnt_o [31:0], which increments each cycle alloc_valid_i=1 and alloc_ready_o=0. It saturates at all-ones and is cleared by reset.
- Adds the output hit_cnt_o [31:0], which counts accepted hits, with the same saturation and reset rules.
- Without the macro: these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then alloc id=0x05 -> slot 0 and ready=1. Next cycle, busy_cnt_o=1 and free_id_o(slot0)=0x05.
- Alloc id 0x05 15 times (CNT_WIDTH=4) -> all go to slot 0 with cnt=15. The 16th request stalls (ready=0). A free on slot 0 brings cnt to 14, and the 16th is accepted the cycle after.
- Alloc 16 distinct IDs 0x00..0x0F -> slots 0..15 and full_o=1. Alloc id 0x20 -> ready=0. Free slot 7 -> next cycle 0x20 gets slot 7.
- Same-cycle accept of a hit on slot 3 (cnt=2) and free of slot 3 -> cnt stays 2 and the id is unchanged.
- Free of slot 9 with cnt=0 -> free_err_o=1 for exactly 1 cycle and busy_cnt_o is unchanged.
- With 3 slots busy, raise drain_req_i -> ready=0. Free all 3 -> drain_done_o=1 one cycle after the last free is registered. Drop drain_req_i -> ready returns to 1 the next cycle.
